// File: rtl/posit_encoder.sv
// posit_encoder: two-stage posit packer and rounder.
// Composes regime/exponent/fraction, then rounds RNE and applies sign.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT16_ES1 = 2'd0,
    POSIT8_ES2  = 2'd1,
    POSIT32_ES2 = 2'd2,
    POSIT64_ES2 = 2'd3
  } posit_format_e;

  function automatic int posit_width(posit_format_e f);
    case (f)
      POSIT16_ES1: return 16;
      POSIT8_ES2:  return 8;
      POSIT32_ES2: return 32;
      default:     return 64;
    endcase
  endfunction

  function automatic int exp_bits(posit_format_e f);
    case (f)
      POSIT16_ES1: return 1;
      default:     return 2;
    endcase
  endfunction

endpackage

module posit_encoder
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat = posit_format_e'(0),
  parameter int unsigned TagWidth = 1,
  localparam int N  = posit_width(pFormat),
  localparam int ES = exp_bits(pFormat),
  localparam int KW = $clog2(N) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                sign_i,
  input  logic signed [KW-1:0] k_i,
  input  logic [ES-1:0]       exponent_i,
  input  logic [2*N-1:0]      mantissa_i,
  input  logic                sticky_i,
  input  logic                zero_i,
  input  logic                nar_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [N-1:0]        result_o,
  output logic                inexact_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                busy_o
);

  localparam int FW = 2*N - 1;
  localparam int SW = 2*N + ES;
  localparam int W  = 3*N + ES;
  localparam int NK = N - 1;
  localparam logic signed [KW-1:0] KMAX = KW'(N - 2);
  localparam logic signed [KW-1:0] KMIN = -KW'(N - 2);

  // Stage 1 registers
  logic                v1_q;
  logic [SW-1:0]       str_q;
  logic                sign_q;
  logic                stk_q;
  logic                zero_q;
  logic                nar_q;
  logic                sathi_q;
  logic                satlo_q;
  logic [TagWidth-1:0] tag1_q;

  // Stage 2 registers
  logic                v2_q;
  logic [N-1:0]        res_q;
  logic                inx_q;
  logic [TagWidth-1:0] tag2_q;

  logic adv2;
  logic acc;
  logic unused_hidden;

  assign unused_hidden = mantissa_i[2*N-1];

  assign adv2       = !v2_q || out_ready_i;
  assign in_ready_o = !flush_i && (!v1_q || adv2);
  assign acc        = in_valid_i && in_ready_o;

  assign out_valid_o = v2_q;
  assign result_o    = res_q;
  assign inexact_o   = inx_q;
  assign tag_o       = tag2_q;
  assign busy_o      = v1_q || v2_q;

  logic signed [KW-1:0] kc;
  logic [KW-1:0]        run;
  logic                 lead;
  logic                 sathi_d;
  logic                 satlo_d;
  logic [W-1:0]         tail;
  logic [W-1:0]         full;
  logic [SW-1:0]        str_d;
  logic                 stk_d;

  // Clamp k and shift the regime run in ahead of exponent and fraction
  always_comb begin
    kc      = k_i;
    sathi_d = 1'b0;
    satlo_d = 1'b0;
    if (k_i > KMAX) begin
      kc      = KMAX;
      sathi_d = 1'b1;
    end else if (k_i < KMIN) begin
      kc      = KMIN;
      satlo_d = 1'b1;
    end
    lead  = !kc[KW-1];
    run   = lead ? (kc + KW'(1)) : (KW'(0) - kc);
    tail  = {!lead, exponent_i, mantissa_i[FW-1:0], {N{1'b0}}};
    full  = lead ? ~((~tail) >> run) : (tail >> run);
    str_d = full[W-1 -: SW];
    stk_d = sticky_i || (|full[N-1:0]);
  end

  logic [NK-1:0] keep;
  logic [NK-1:0] rnd;
  logic          g;
  logic          s;
  logic          inc;
  logic          minfix;
  logic [N-1:0]  mag;
  logic [N-1:0]  res_d;
  logic          inx_d;

  // Round to nearest even, saturate, then apply sign and specials
  always_comb begin
    keep   = str_q[SW-1 -: NK];
    g      = str_q[SW-N];
    s      = (|str_q[SW-N-1:0]) || stk_q;
    inc    = g && (s || keep[0]);
    rnd    = (inc && !(&keep)) ? keep + NK'(1) : keep;
    minfix = 1'b0;
    if (sathi_q) begin
      rnd = '1;
    end else if (satlo_q) begin
      rnd = NK'(1);
    end else if (rnd == '0) begin
      rnd    = NK'(1);
      minfix = 1'b1;
    end
    mag   = {1'b0, rnd};
    res_d = sign_q ? (~mag + N'(1)) : mag;
    inx_d = g || s || sathi_q || satlo_q || minfix;
    if (nar_q) begin
      res_d = {1'b1, {(N-1){1'b0}}};
      inx_d = 1'b0;
    end else if (zero_q) begin
      res_d = '0;
      inx_d = 1'b0;
    end
  end

  // Stage valids: flush kills both, otherwise advance on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (flush_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (!v1_q || adv2) v1_q <= acc;
      if (adv2)          v2_q <= v1_q;
    end
  end

  // Stage 1 data loads only on an accepted input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      str_q   <= '0;
      sign_q  <= 1'b0;
      stk_q   <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      sathi_q <= 1'b0;
      satlo_q <= 1'b0;
      tag1_q  <= '0;
    end else if (acc) begin
      str_q   <= str_d;
      sign_q  <= sign_i;
      stk_q   <= stk_d;
      zero_q  <= zero_i;
      nar_q   <= nar_i;
      sathi_q <= sathi_d;
      satlo_q <= satlo_d;
      tag1_q  <= tag_i;
    end
  end

  // Stage 2 data loads when a valid stage-1 entry moves forward
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q  <= '0;
      inx_q  <= 1'b0;
      tag2_q <= '0;
    end else if (adv2 && v1_q && !flush_i) begin
      res_q  <= res_d;
      inx_q  <= inx_d;
      tag2_q <= tag1_q;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: directed checks for posit_encoder, N=16 ES=1.
// Expected words are hand-computed posit encodings.
module tb_posit_encoder;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              sign;
  logic signed [4:0] k;
  logic [0:0]        expo;
  logic [31:0]       mant;
  logic              sticky;
  logic              zero;
  logic              nar;
  logic [3:0]        tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       result;
  logic              inexact;
  logic [3:0]        tag_out;
  logic              busy;

  int checks;
  int errors;

  posit_encoder #(.TagWidth(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sign_i      (sign),
    .k_i         (k),
    .exponent_i  (expo),
    .mantissa_i  (mant),
    .sticky_i    (sticky),
    .zero_i      (zero),
    .nar_i       (nar),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .inexact_o   (inexact),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // top 14 bits: hidden, 12 fraction bits, guard
  function automatic logic [31:0] mk(input logic [13:0] m14);
    return {m14, 18'b0};
  endfunction

  task automatic drive(input logic sg, input logic signed [4:0] kk,
                       input logic e, input logic [13:0] m14,
                       input logic st, input logic z, input logic n,
                       input logic [3:0] t);
    sign   = sg;
    k      = kk;
    expo   = e;
    mant   = mk(m14);
    sticky = st;
    zero   = z;
    nar    = n;
    tag_in = t;
  endtask

  task automatic vec(input string name, input logic sg,
                     input logic signed [4:0] kk, input logic e,
                     input logic [13:0] m14, input logic st,
                     input logic z, input logic n,
                     input logic [15:0] er, input logic ei);
    @(negedge clk);
    drive(sg, kk, e, m14, st, z, n, 4'h5);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_res"}, 32'(result), 32'(er));
    chk({name, "_inx"}, 32'(inexact), 32'(ei));
  endtask

  logic [15:0] exp_q[5];
  int sent;
  int rcvd;
  int outs;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 5'sd0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    #12;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_inx", 32'(inexact), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    vec("one",     0, 5'sd0,  0, 14'h2000, 0, 0, 0, 16'h4000, 0);
    vec("neg_one", 1, 5'sd0,  0, 14'h2000, 0, 0, 0, 16'hC000, 0);
    vec("frac_h",  0, 5'sd0,  0, 14'h3000, 0, 0, 0, 16'h4800, 0);
    vec("km1_e1",  0, -5'sd1, 1, 14'h2000, 0, 0, 0, 16'h3000, 0);
    vec("tie_ev",  0, 5'sd0,  0, 14'h2001, 0, 0, 0, 16'h4000, 1);
    vec("tie_stk", 0, 5'sd0,  0, 14'h2001, 1, 0, 0, 16'h4001, 1);
    vec("tie_odd", 0, 5'sd0,  0, 14'h2003, 0, 0, 0, 16'h4002, 1);
    vec("k14_ovf", 0, 5'sd14, 0, 14'h3FFF, 0, 0, 0, 16'h7FFF, 1);
    vec("k_hi",    0, 5'sd15, 0, 14'h2000, 0, 0, 0, 16'h7FFF, 1);
    vec("k_lo",    0, -5'sd16, 0, 14'h2000, 0, 0, 0, 16'h0001, 1);
    vec("neg_khi", 1, 5'sd15, 0, 14'h2000, 0, 0, 0, 16'h8001, 1);
    vec("zero",    1, 5'sd3,  1, 14'h3FFF, 1, 1, 0, 16'h0000, 0);
    vec("nar",     0, 5'sd3,  1, 14'h3FFF, 1, 1, 1, 16'h8000, 0);

    // backpressure: 5 inputs, out_ready low for the first 4 cycles
    for (int i = 0; i < 5; i++) exp_q[i] = 16'h4000 | 16'(i);
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 5; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      in_valid  = (sent < 5);
      drive(0, 5'sd0, 0, 14'h2000 | 14'(sent << 1), 0, 0, 0,
            4'(sent + 1));
      #1;
      if (c == 2) chk("bp_rdy_low", 32'(in_ready), 32'd0);
      if (c == 3) chk("bp_hold", 32'(result), 32'(exp_q[0]));
      if (out_valid && out_ready) begin
        chk("bp_res", 32'(result), 32'(exp_q[rcvd]));
        chk("bp_tag", 32'(tag_out), 32'(rcvd + 1));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_count", 32'(rcvd), 32'd5);
    @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // flush with two in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(0, 5'sd0, 0, 14'h2000, 0, 0, 0, 4'(i + 7));
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_busy_pre", 32'(busy), 32'd1);
    chk("fl_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_busy", 32'(busy), 32'd0);
    outs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) outs++;
    end
    chk("fl_no_out", 32'(outs), 32'd0);

    // async reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(0, 5'sd1, 0, 14'h2000, 0, 0, 0, 4'hA);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    drive(0, 5'sd1, 0, 14'h2000, 0, 0, 0, 4'hC);
    #1;
    chk("lat_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2", 32'(out_valid), 32'd1);
    chk("lat_res", 32'(result), 32'h6000);
    chk("lat_tag", 32'(tag_out), 32'hC);
    @(negedge clk);
    chk("lat_once", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
